code_mem_loader: RTL and testbench
==================================

Name: code_mem_loader

Overview:
- Writer side of the byte-wide instruction code memory. The CPU fetch path reads that memory as big-endian words {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- Accepts a framed byte stream over a valid/ready handshake and writes the payload into the code memory one byte per cycle.
- Verifies an XOR checksum over the payload.
- Holds the CPU in reset (cpu_hold) while a load is in progress, so a program can be replaced without resynthesising the memory image.

Parameters:
- MEM_BYTES, 128, code memory size in bytes; must be a multiple of 4. Maximum word count MAX_WORDS = MEM_BYTES/4.
- BASE_ADDR, 0, byte address of the first payload byte.

Ports:
- CLK  in  1  system clock; all logic on its rising edge
- my_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  byte write strobe to code memory
- mem_addr  out  32  byte write address
- mem_wdata  out  8  byte write data
- cpu_hold  out  1  drives CPU reset while loading
- done  out  1  load completed with good checksum; level
- error  out  1  load aborted; level
- words_loaded  out  6  word count N from the last accepted header

Behaviour:
- Reset: state=IDLE; all outputs 0; byte counter, address register and checksum cleared.
  - Reset mid-load returns to IDLE at once. Bytes already written stay in memory; no further writes occur.
- Accept rule: a byte is accepted on a clock edge where byte_valid && byte_ready. byte_ready is a registered function of state: 1 in LEN, DATA and CHK, 0 elsewhere. byte_in is ignored when not accepted.
- Frame format: one length byte N, then 4N payload bytes, then one checksum byte.
  - Payload byte k goes to address BASE_ADDR+k. The MSB of each word therefore comes first, matching the fetch order.
- States:
  - IDLE: all handshake outputs idle.
    - start → LEN. cpu_hold=1, done=0, error=0, checksum=0, byte counter=0.
  - LEN: on accept, capture N into words_loaded.
    - If N==0 or N>MAX_WORDS → ERR.
    - Otherwise → DATA.
  - DATA: on accept, register mem_we=1, mem_addr=BASE_ADDR+count, mem_wdata=byte_in for exactly the next cycle (1-cycle write latency). Then checksum ^= byte_in and count++.
    - When the byte with count==4N−1 is accepted → CHK.
  - CHK: on accept, compare byte_in with checksum.
    - Equal → DONE.
    - Unequal → ERR.
  - DONE: done=1, cpu_hold=0 (both take effect the cycle after the checksum byte is accepted).
  - ERR: error=1, cpu_hold stays 1 so the CPU never runs a bad image.
  - start in DONE or ERR clears done/error and re-enters LEN. start in LEN, DATA or CHK is ignored.
- mem_we is never asserted outside the cycle after a DATA accept. mem_addr is never ≥ BASE_ADDR+MEM_BYTES; the N check guarantees this, and the address does not wrap.
- Stalls: byte_valid low for any number of cycles leaves state and counters unchanged; there is no timeout.
- Back-to-back accepts at one byte per cycle are supported (full throughput).
- A start coinciding with my_reset: reset wins.
- Count and checksum widths: count is 8 bits (4×MAX_WORDS−1 ≤ 127); checksum is 8 bits.

Test Plan:
- Reset, then start, then frame 01,E3,A0,00,01,cks=42 sent back-to-back → mem_we pulses at addresses 0–3 with data E3,A0,00,01; done=1 and cpu_hold=0 on the cycle after the checksum byte is accepted; words_loaded=1; the fetch at pc=0 reads E3A00001.
- Same frame with checksum 43 → error=1, done=0, cpu_hold remains 1; all 4 memory writes still observed.
- Length byte 00, and separately 21 (33 > MAX_WORDS) → ERR immediately after the length byte; zero mem_we pulses.
- Frame of N=32 (128 bytes) with byte_valid toggled randomly 50% → last write at address 127, done=1, no write to address ≥128, byte_ready held high through DATA.
- my_reset asserted after 2 payload bytes of an N=2 frame → next cycle state is IDLE, all outputs 0; the following start plus a full frame loads correctly.
- start pulsed during DATA → ignored; then start pulsed in DONE → done drops to 0, cpu_hold returns to 1, LEN expects a new length byte.

Source files
------------

// File: rtl/code_mem_loader.sv
// Writer side of the byte-wide code memory: receives a length-prefixed, XOR-checked
// byte frame and streams the payload into memory while holding the CPU in reset.
module code_mem_loader #(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        CLK,
    input  logic        my_reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [5:0]  words_loaded
);

    localparam int unsigned MAX_WORDS = MEM_BYTES / 4;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  cks_q, cks_d;
    logic [5:0]  words_q, words_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    logic       accept;
    logic [7:0] last_count;

    // Handshake and hold outputs are pure decodes of the registered state.
    assign byte_ready   = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
    assign cpu_hold     = byte_ready || (state_q == StErr);
    assign done         = (state_q == StDone);
    assign error        = (state_q == StErr);
    assign words_loaded = words_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

    assign accept     = byte_valid && byte_ready;
    assign last_count = {words_q, 2'b00} - 8'd1;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cks_d       = cks_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLen;
                    count_d = 8'd0;
                    cks_d   = 8'd0;
                end
            end
            StLen: begin
                if (accept) begin
                    words_d = byte_in[5:0];
                    // Range check on the full byte keeps every address inside the memory.
                    if (byte_in == 8'd0 || 32'(byte_in) > MAX_WORDS) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_ADDR + 32'(count_q);
                    mem_wdata_d = byte_in;
                    cks_d       = cks_q ^ byte_in;
                    count_d     = count_q + 8'd1;
                    if (count_q == last_count) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (accept) begin
                    state_d = (byte_in == cks_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (my_reset) begin
            state_q     <= StIdle;
            count_q     <= 8'd0;
            cks_q       <= 8'd0;
            words_q     <= 6'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cks_q       <= cks_d;
            words_q     <= words_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_code_mem_loader.sv
// Directed bench for code_mem_loader: drives frames on the falling edge, samples on the
// falling edge, and mirrors memory writes into a local byte array.
module tb_code_mem_loader;

    logic        CLK = 1'b0;
    logic        my_reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [5:0]  words_loaded;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int bad_addr = 0;
    int rdy_low = 0;
    logic [31:0] last_addr = 32'd0;
    logic [7:0]  tbmem [0:255];

    code_mem_loader #(
        .MEM_BYTES (128),
        .BASE_ADDR (0)
    ) dut (
        .CLK          (CLK),
        .my_reset     (my_reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    // mem_we lasts exactly one cycle, so each write is seen at exactly one falling edge.
    always @(negedge CLK) begin
        if (mem_we) begin
            tbmem[mem_addr[7:0]] = mem_wdata;
            we_cnt++;
            last_addr = mem_addr;
            if (mem_addr >= 32'd128) bad_addr++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) tbmem[i] = 8'h55;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge CLK);
        byte_valid = 1'b0;
    endtask

    // Present one byte; it is accepted on the rising edge after byte_ready is seen high.
    task automatic send_byte(input logic [7:0] b, input bit rnd, input bit in_data);
        int guard;
        guard = 0;
        if (rnd) begin
            while ($urandom_range(1, 0) == 1 && guard < 8) begin
                @(negedge CLK);
                byte_valid = 1'b0;
                if (in_data && !byte_ready) rdy_low++;
                guard++;
            end
        end
        @(negedge CLK);
        byte_in    = b;
        byte_valid = 1'b1;
        if (in_data && !byte_ready) rdy_low++;
        guard = 0;
        while (!byte_ready && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 200) check_eq("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame1(input logic [7:0] cks);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'hE3, 1'b0, 1'b1);
        send_byte(8'hA0, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0, 1'b1);
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(cks, 1'b0, 1'b0);
        idle_cycle();
    endtask

    initial begin
        int w0;
        logic [7:0] d;
        logic [7:0] cks;
        my_reset   = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        clear_mem();
        repeat (3) @(negedge CLK);

        // Reset state, with a start held during reset that must lose.
        start = 1'b1;
        @(negedge CLK);
        check_eq("rst_outputs",
                 {22'd0, byte_ready, mem_we, cpu_hold, done, error, words_loaded == 6'd0,
                  mem_addr == 32'd0, mem_wdata == 8'd0, 2'b00},
                 {22'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00});
        start    = 1'b0;
        my_reset = 1'b0;

        // Good frame, back-to-back.
        w0 = we_cnt;
        pulse_start();
        check_eq("len_ready", {31'd0, byte_ready}, 32'd1);
        check_eq("len_hold", {31'd0, cpu_hold}, 32'd1);
        send_frame1(8'h42);
        check_eq("t1_done", {31'd0, done}, 32'd1);
        check_eq("t1_hold", {31'd0, cpu_hold}, 32'd0);
        check_eq("t1_error", {31'd0, error}, 32'd0);
        check_eq("t1_words", {26'd0, words_loaded}, 32'd1);
        check_eq("t1_we_cnt", we_cnt - w0, 32'd4);
        check_eq("t1_fetch", {tbmem[0], tbmem[1], tbmem[2], tbmem[3]}, 32'hE3A00001);
        check_eq("t1_ready_done", {31'd0, byte_ready}, 32'd0);

        // Bad checksum.
        clear_mem();
        w0 = we_cnt;
        pulse_start();
        send_frame1(8'h43);
        check_eq("t2_error", {31'd0, error}, 32'd1);
        check_eq("t2_done", {31'd0, done}, 32'd0);
        check_eq("t2_hold", {31'd0, cpu_hold}, 32'd1);
        check_eq("t2_we_cnt", we_cnt - w0, 32'd4);
        check_eq("t2_fetch", {tbmem[0], tbmem[1], tbmem[2], tbmem[3]}, 32'hE3A00001);

        // Length 0 and length 33 go straight to ERR with no writes.
        w0 = we_cnt;
        pulse_start();
        send_byte(8'h00, 1'b0, 1'b0);
        idle_cycle();
        check_eq("len0_error", {31'd0, error}, 32'd1);
        check_eq("len0_hold", {31'd0, cpu_hold}, 32'd1);
        pulse_start();
        check_eq("restart_err_clr", {31'd0, error}, 32'd0);
        send_byte(8'h21, 1'b0, 1'b0);
        idle_cycle();
        check_eq("len33_error", {31'd0, error}, 32'd1);
        check_eq("len33_words", {26'd0, words_loaded}, 32'd33);
        repeat (3) @(negedge CLK);
        check_eq("len_err_no_we", we_cnt - w0, 32'd0);

        // Full 32-word frame with random valid gaps.
        clear_mem();
        w0 = we_cnt;
        rdy_low = 0;
        bad_addr = 0;
        cks = 8'h00;
        pulse_start();
        send_byte(8'd32, 1'b1, 1'b0);
        for (int k = 0; k < 128; k++) begin
            d = 8'(k * 7 + 3);
            cks = cks ^ d;
            send_byte(d, 1'b1, 1'b1);
        end
        send_byte(cks, 1'b1, 1'b0);
        idle_cycle();
        check_eq("big_done", {31'd0, done}, 32'd1);
        check_eq("big_we_cnt", we_cnt - w0, 32'd128);
        check_eq("big_last_addr", last_addr, 32'd127);
        check_eq("big_bad_addr", bad_addr, 32'd0);
        check_eq("big_ready_low", rdy_low, 32'd0);
        check_eq("big_mem127", {24'd0, tbmem[127]}, 32'd124);
        check_eq("big_fetch4", {tbmem[4], tbmem[5], tbmem[6], tbmem[7]}, 32'h1F262D34);

        // Reset in the middle of a load.
        pulse_start();
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        @(negedge CLK);
        byte_valid = 1'b0;
        my_reset   = 1'b1;
        @(negedge CLK);
        check_eq("midrst_outputs",
                 {byte_ready, mem_we, cpu_hold, done, error, words_loaded == 6'd0,
                  mem_addr == 32'd0, mem_wdata == 8'd0},
                 {8'b00000111});
        my_reset = 1'b0;
        w0 = we_cnt;
        repeat (2) @(negedge CLK);
        check_eq("midrst_no_we", we_cnt - w0, 32'd0);
        clear_mem();
        pulse_start();
        send_frame1(8'h42);
        check_eq("midrst_reload_done", {31'd0, done}, 32'd1);
        check_eq("midrst_fetch", {tbmem[0], tbmem[1], tbmem[2], tbmem[3]}, 32'hE3A00001);

        // start during DATA is ignored; start in DONE restarts.
        clear_mem();
        pulse_start();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'hE3, 1'b0, 1'b1);
        pulse_start();
        check_eq("data_start_ignored", {31'd0, byte_ready}, 32'd1);
        send_byte(8'hA0, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0, 1'b1);
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(8'h42, 1'b0, 1'b0);
        idle_cycle();
        check_eq("data_start_done", {31'd0, done}, 32'd1);
        pulse_start();
        check_eq("rest_done_clr", {31'd0, done}, 32'd0);
        check_eq("rest_hold", {31'd0, cpu_hold}, 32'd1);
        check_eq("rest_ready", {31'd0, byte_ready}, 32'd1);
        // New length byte of 2 words: 11 22 33 44 55 66 77 88, xor = 88.
        clear_mem();
        send_byte(8'h02, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            d = 8'(k * 8'h11);
            send_byte(d, 1'b0, 1'b1);
        end
        send_byte(8'h88, 1'b0, 1'b0);
        idle_cycle();
        check_eq("rest_done", {31'd0, done}, 32'd1);
        check_eq("rest_words", {26'd0, words_loaded}, 32'd2);
        check_eq("rest_fetch4", {tbmem[4], tbmem[5], tbmem[6], tbmem[7]}, 32'h55667788);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
